// File: rtl/mem_arbiter.sv
// Two-requester arbiter (core C, loader L) for the single-port unified memory.
// Combinational grant, 1-cycle read return, loader burst lock with bounded core starvation.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAXLOCK = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] MAXCNT = CW'(MAXLOCK);

  typedef enum logic [1:0] {ARB, LOCK, FORCE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_L} owner_t;

  state_t        state_q, state_d;
  owner_t        rd_owner_q, rd_owner_d;
  logic          last_l_q, last_l_d;
  logic [CW-1:0] lockcnt_q, lockcnt_d;

  // State register; reset drops any pending read return and releases the lock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB;
      last_l_q   <= 1'b1;
      lockcnt_q  <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      last_l_q   <= last_l_d;
      lockcnt_q  <= lockcnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Grant decision and next-state logic.
  always_comb begin
    state_d   = state_q;
    last_l_d  = last_l_q;
    lockcnt_d = lockcnt_q;
    c_gnt     = 1'b0;
    l_gnt     = 1'b0;
    case (state_q)
      ARB: begin
        if (c_req && (!l_req || last_l_q)) begin
          c_gnt    = 1'b1;
          last_l_d = 1'b0;
        end else if (l_req) begin
          l_gnt    = 1'b1;
          last_l_d = 1'b1;
          if (l_lock) begin
            state_d   = LOCK;
            lockcnt_d = CW'(1);
          end
        end
      end
      LOCK: begin
        if (!l_lock) begin
          state_d  = ARB;
          last_l_d = 1'b1;
        end else if (lockcnt_q == MAXCNT && c_req) begin
          state_d = FORCE;
        end else if (l_req) begin
          l_gnt = 1'b1;
          if (lockcnt_q != MAXCNT) lockcnt_d = lockcnt_q + CW'(1);
        end
      end
      FORCE: begin
        state_d = l_lock ? LOCK : ARB;
        if (c_req) begin
          c_gnt     = 1'b1;
          last_l_d  = 1'b0;
          lockcnt_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
    if (!reset) begin
      c_gnt = 1'b0;
      l_gnt = 1'b0;
    end
  end

  // Memory port mux; idle port is parked at zero.
  assign m_en    = c_gnt | l_gnt;
  assign m_we    = c_gnt ? c_we    : (l_gnt ? l_we    : 1'b0);
  assign m_addr  = c_gnt ? c_addr  : (l_gnt ? l_addr  : '0);
  assign m_wdata = c_gnt ? c_wdata : (l_gnt ? l_wdata : '0);

  // Remember whose read is in flight so the returning data is steered to it.
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (c_gnt && !c_we)      rd_owner_d = OWN_C;
    else if (l_gnt && !l_we) rd_owner_d = OWN_L;
  end

  assign c_rvalid = (rd_owner_q == OWN_C);
  assign l_rvalid = (rd_owner_q == OWN_L);
  assign c_rdata  = c_rvalid ? m_rdata : '0;
  assign l_rdata  = l_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous RAM model behind the memory port.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata;

  logic [31:0] mem [0:255];
  logic        mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MAXLOCK(16)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Word-addressed RAM; word i starts out holding 0x5A00_0000 | i.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
      mem_ready <= 1'b1;
    end else if (m_en) begin
      if (m_we) mem[m_addr[9:2]] <= m_wdata;
      else      m_rdata <= mem[m_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        prev_l;
    logic        exp_l, exp_c;
    logic [31:0] exp_w;
    int          wi;

    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0; l_lock = 1'b0;

    // Reset held with the core requesting
    repeat (2) @(negedge clk);
    #1;
    chk("rst_c_gnt", 32'(c_gnt), 32'd0);
    chk("rst_l_gnt", 32'(l_gnt), 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_l_rvalid", 32'(l_rvalid), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_c_gnt", 32'(c_gnt), 32'd1);
    chk("rel_m_en", 32'(m_en), 32'd1);
    chk("rel_m_addr", m_addr, 32'h10);
    chk("rel_m_we", 32'(m_we), 32'd0);
    @(negedge clk);
    chk("rel_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("rel_c_rdata", c_rdata, 32'h5A00_0004);
    chk("rel_l_rvalid", 32'(l_rvalid), 32'd0);
    c_req = 1'b0;

    // Unlocked round robin from a fresh reset: C first
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk($sformatf("rr%0d_c_rvalid", k), 32'(c_rvalid), 32'(((k - 1) % 2) == 0));
        chk($sformatf("rr%0d_l_rvalid", k), 32'(l_rvalid), 32'(((k - 1) % 2) == 1));
        chk($sformatf("rr%0d_c_rdata", k), c_rdata, (((k - 1) % 2) == 0) ? 32'h5A00_0008 : 32'h0);
        chk($sformatf("rr%0d_l_rdata", k), l_rdata, (((k - 1) % 2) == 1) ? 32'h5A00_000C : 32'h0);
      end
      c_req = (k < 4); c_addr = 32'h20;
      l_req = (k < 4); l_addr = 32'h30;
      #1;
      if (k < 4) begin
        chk($sformatf("rr%0d_c_gnt", k), 32'(c_gnt), 32'((k % 2) == 0));
        chk($sformatf("rr%0d_l_gnt", k), 32'(l_gnt), 32'((k % 2) == 1));
      end
    end

    // Locked loader write burst with the core waiting
    @(negedge clk);
    wi = 0;
    l_req = 1'b1; l_lock = 1'b1; l_we = 1'b1;
    l_addr = 32'hA0; l_wdata = 32'hB000_0000;
    #1;
    chk("lock0_l_gnt", 32'(l_gnt), 32'd1);
    chk("lock0_m_we", 32'(m_we), 32'd1);
    chk("lock0_m_wdata", m_wdata, 32'hB000_0000);
    prev_l = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      if (prev_l) begin
        wi++;
        l_addr  = 32'hA0 + 32'(4 * (wi % 8));
        l_wdata = 32'hB000_0000 + 32'(wi);
      end
      if (t == 1) begin
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10;
      end
      if (t == 18) begin
        chk("force_c_rvalid", 32'(c_rvalid), 32'd1);
        chk("force_c_rdata", c_rdata, 32'h5A00_0004);
        c_req = 1'b0;
      end
      exp_l = (t <= 15) || (t == 18);
      exp_c = (t == 17);
      #1;
      chk($sformatf("lock%0d_l_gnt", t), 32'(l_gnt), 32'(exp_l));
      chk($sformatf("lock%0d_c_gnt", t), 32'(c_gnt), 32'(exp_c));
      prev_l = exp_l;
    end
    @(negedge clk);
    l_req = 1'b0; l_lock = 1'b0; l_we = 1'b0;
    #1;
    chk("unlock_l_gnt", 32'(l_gnt), 32'd0);
    for (int j = 0; j < 8; j++) begin
      exp_w = (j == 0) ? 32'hB000_0010 : 32'hB000_0008 + 32'(j);
      chk($sformatf("burst_mem%0d", j), mem[40 + j], exp_w);
    end

    // Loader drops the lock after three grants while the core waits
    @(negedge clk);
    l_req = 1'b1; l_lock = 1'b1; l_addr = 32'h30;
    #1;
    chk("drop0_l_gnt", 32'(l_gnt), 32'd1);
    for (int u = 1; u <= 2; u++) begin
      @(negedge clk);
      chk($sformatf("drop%0d_l_rvalid", u), 32'(l_rvalid), 32'd1);
      chk($sformatf("drop%0d_l_rdata", u), l_rdata, 32'h5A00_000C);
      c_req = 1'b1; c_addr = 32'h20;
      #1;
      chk($sformatf("drop%0d_l_gnt", u), 32'(l_gnt), 32'd1);
      chk($sformatf("drop%0d_c_gnt", u), 32'(c_gnt), 32'd0);
    end
    @(negedge clk);
    chk("drop3_l_rvalid", 32'(l_rvalid), 32'd1);
    l_lock = 1'b0;
    #1;
    chk("drop3_l_gnt", 32'(l_gnt), 32'd0);
    chk("drop3_c_gnt", 32'(c_gnt), 32'd0);
    @(negedge clk);
    chk("drop4_l_rvalid", 32'(l_rvalid), 32'd0);
    #1;
    chk("drop4_c_gnt", 32'(c_gnt), 32'd1);
    chk("drop4_l_gnt", 32'(l_gnt), 32'd0);
    @(negedge clk);
    chk("drop5_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("drop5_c_rdata", c_rdata, 32'h5A00_0008);
    c_req = 1'b0;
    #1;
    chk("drop5_l_gnt", 32'(l_gnt), 32'd1);

    // Core write and loader read of the same word, core first
    @(negedge clk);
    chk("drop6_l_rvalid", 32'(l_rvalid), 32'd1);
    chk("drop6_c_rvalid", 32'(c_rvalid), 32'd0);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'hDEAD_BEEF;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h40;
    #1;
    chk("wr_c_gnt", 32'(c_gnt), 32'd1);
    chk("wr_l_gnt", 32'(l_gnt), 32'd0);
    chk("wr_m_we", 32'(m_we), 32'd1);
    chk("wr_m_addr", m_addr, 32'h40);
    chk("wr_m_wdata", m_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_c_rvalid", 32'(c_rvalid), 32'd0);
    c_req = 1'b0; c_we = 1'b0; c_wdata = '0;
    #1;
    chk("rd_l_gnt", 32'(l_gnt), 32'd1);
    chk("rd_m_we", 32'(m_we), 32'd0);
    @(negedge clk);
    chk("rd_l_rvalid", 32'(l_rvalid), 32'd1);
    chk("rd_l_rdata", l_rdata, 32'hDEAD_BEEF);
    chk("rd_c_rvalid", 32'(c_rvalid), 32'd0);
    l_req = 1'b0;
    #1;
    chk("idle_m_en", 32'(m_en), 32'd0);
    chk("idle_m_we", 32'(m_we), 32'd0);
    chk("idle_m_addr", m_addr, 32'h0);

    // Async reset during a granted locked loader read
    @(negedge clk);
    l_req = 1'b1; l_lock = 1'b1; l_addr = 32'h30;
    #1;
    chk("ar0_l_gnt", 32'(l_gnt), 32'd1);
    @(negedge clk);
    chk("ar1_l_rvalid", 32'(l_rvalid), 32'd1);
    #1;
    chk("ar1_l_gnt", 32'(l_gnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar1_rst_l_gnt", 32'(l_gnt), 32'd0);
    chk("ar1_rst_m_en", 32'(m_en), 32'd0);
    @(negedge clk);
    chk("ar2_l_rvalid", 32'(l_rvalid), 32'd0);
    chk("ar2_l_rdata", l_rdata, 32'h0);
    reset = 1'b1;
    c_req = 1'b1; c_addr = 32'h10;
    #1;
    chk("ar2_c_gnt", 32'(c_gnt), 32'd1);
    chk("ar2_l_gnt", 32'(l_gnt), 32'd0);
    @(negedge clk);
    chk("ar3_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("ar3_c_rdata", c_rdata, 32'h5A00_0004);
    c_req = 1'b0;
    #1;
    chk("ar3_l_gnt", 32'(l_gnt), 32'd1);
    @(negedge clk);
    l_req = 1'b0; l_lock = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
